// File: rtl/jt51_wrseq.sv
// Register-write sequencer for the JT51 FM core.
// Host (register, value) pairs are queued in a small FIFO and replayed
// onto the chip's CPU bus as address/data strobes. Repeated writes to the
// same register skip the address phase, and each write then waits for the
// chip's busy flag to clear (bounded by a timeout).
module jt51_wrseq #(
  parameter int FIFO_DEPTH = 4,
  parameter int BUSY_TMO   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic [7:0] cpu_din,
  output logic       cpu_write,
  output logic       cpu_a0,
  input  logic       busy,
  output logic       idle,
  output logic       timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TMO + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    GAP,
    WR_DATA,
    WAIT_SET,
    WAIT_BUSY
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic [7:0]    head_addr, head_data;

  logic [7:0]    addr_q, data_q;
  logic [7:0]    last_addr;
  logic          last_addr_valid;
  logic          set_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  logic          write_nxt, a0_nxt;
  logic [7:0]    din_nxt;

  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head_addr = mem[rd_ptr][15:8];
  assign head_data = mem[rd_ptr][7:0];
  assign idle      = (count == '0) && (state == IDLE);

  // Occupancy after this cycle's push/pop; ready is registered from it so
  // that the host sees "not full" without a combinational path.
  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {req_addr, req_data};
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      req_ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic; a busy wait ends on busy low or on the timeout count.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:
        if (count != '0)
          state_nxt = (!last_addr_valid || head_addr != last_addr) ? WR_ADDR : WR_DATA;
      WR_ADDR:  state_nxt = GAP;
      GAP:      state_nxt = WR_DATA;
      WR_DATA:  state_nxt = WAIT_SET;
      WAIT_SET:
        if (set_cnt)
          state_nxt = WAIT_BUSY;
      WAIT_BUSY:
        if (!busy)
          state_nxt = IDLE;
        else if (clk_en && tmo_cnt == TW'(BUSY_TMO - 1)) begin
          state_nxt = IDLE;
          tmo_hit   = 1'b1;
        end
      default:  state_nxt = IDLE;
    endcase
  end

  // Bus values for the coming cycle; a0/din hold unless a strobe is issued.
  always_comb begin
    write_nxt = 1'b0;
    a0_nxt    = cpu_a0;
    din_nxt   = cpu_din;
    case (state_nxt)
      WR_ADDR: begin
        write_nxt = 1'b1;
        a0_nxt    = 1'b0;
        din_nxt   = head_addr;
      end
      WR_DATA: begin
        write_nxt = 1'b1;
        a0_nxt    = 1'b1;
        din_nxt   = (state == IDLE) ? head_data : data_q;
      end
      default: ;
    endcase
  end

  // Holding registers, address-skip memory, wait counters and bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= 8'h00;
      data_q          <= 8'h00;
      last_addr       <= 8'h00;
      last_addr_valid <= 1'b0;
      set_cnt         <= 1'b0;
      tmo_cnt         <= '0;
      timeout         <= 1'b0;
      cpu_write       <= 1'b0;
      cpu_a0          <= 1'b0;
      cpu_din         <= 8'h00;
    end else begin
      if (pop) begin
        addr_q <= head_addr;
        data_q <= head_data;
      end
      if (state == WR_ADDR) begin
        last_addr       <= addr_q;
        last_addr_valid <= 1'b1;
      end
      set_cnt <= (state == WAIT_SET) ? ~set_cnt : 1'b0;
      if (state == WR_DATA)
        tmo_cnt <= '0;
      else if (state == WAIT_BUSY && clk_en)
        tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit)
        timeout <= 1'b1;
      cpu_write <= write_nxt;
      cpu_a0    <= a0_nxt;
      cpu_din   <= din_nxt;
    end
  end

endmodule

// File: tb/tb_jt51_wrseq.sv
// Directed testbench for jt51_wrseq: reset state, single write timing,
// address skip, FIFO full back-pressure, busy wait, timeout and abort.
module tb_jt51_wrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic [7:0] cpu_din;
  logic       cpu_write;
  logic       cpu_a0;
  logic       busy = 1'b0;
  logic       idle;
  logic       timeout;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  halfrate = 1'b0;
  logic [8:0] strobe_q[$];

  jt51_wrseq #(.FIFO_DEPTH(4), .BUSY_TMO(64)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .cpu_din(cpu_din), .cpu_write(cpu_write), .cpu_a0(cpu_a0),
    .busy(busy), .idle(idle), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Log every strobe as {a0, din}, sampled mid-cycle.
  always @(negedge clk) begin
    if (cpu_write)
      strobe_q.push_back({cpu_a0, cpu_din});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (halfrate)
      clk_en = ~clk_en;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] d, output bit ok);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (req_ready)
        ok = 1'b1;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_write(input int bound, output int n, output bit found);
    found = 1'b0;
    n = 0;
    while (!found && n < bound) begin
      if (cpu_write)
        found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!idle && n < 400) begin
      tick();
      n++;
    end
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_idle_wait: idle=%b after %0d cycles, required 1", tag, idle, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({idle, req_ready, cpu_write, cpu_a0, timeout} !== 5'b11000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: idle/ready/wr/a0/tmo=%b required 11000",
               {idle, req_ready, cpu_write, cpu_a0, timeout});
    end
    n_tests++;
    if (cpu_din !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_din: got %h required 00", cpu_din);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [10:0] exp_seq [7];
    busy = 1'b0;
    clk_en = 1'b1;
    // {write, a0, din} per cycle after acceptance; last cycle checks idle
    exp_seq[0] = {1'b1, 1'b0, 8'h20, 1'b0};
    exp_seq[1] = {1'b0, 1'b0, 8'h20, 1'b0};
    exp_seq[2] = {1'b1, 1'b1, 8'hC7, 1'b0};
    exp_seq[3] = {1'b0, 1'b1, 8'hC7, 1'b0};
    exp_seq[4] = {1'b0, 1'b1, 8'hC7, 1'b0};
    exp_seq[5] = {1'b0, 1'b1, 8'hC7, 1'b0};
    exp_seq[6] = {1'b0, 1'b1, 8'hC7, 1'b1};
    push_pair(8'h20, 8'hC7, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL single_accept: pair not accepted, required accepted");
    end
    for (int c = 0; c < 7; c++) begin
      tick();
      n_tests++;
      if ({cpu_write, cpu_a0, cpu_din, idle} !== exp_seq[c]) begin
        n_fail++;
        $display("[TB] FAIL single_cycle%0d: wr/a0/din/idle=%b/%b/%h/%b required %b/%b/%h/%b",
                 c + 1, cpu_write, cpu_a0, cpu_din, idle,
                 exp_seq[c][10], exp_seq[c][9], exp_seq[c][8:1], exp_seq[c][0]);
      end
    end
  endtask

  task automatic test_addr_skip();
    bit ok1, ok2;
    strobe_q.delete();
    push_pair(8'h28, 8'h4A, ok1);
    push_pair(8'h28, 8'h3E, ok2);
    wait_idle("skip");
    tick();
    n_tests++;
    if (!(ok1 && ok2) || strobe_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL skip_count: %0d strobes, required 3", strobe_q.size());
    end else begin
      n_tests++;
      if (strobe_q[0] !== 9'h028 || strobe_q[1] !== 9'h14A || strobe_q[2] !== 9'h13E) begin
        n_fail++;
        $display("[TB] FAIL skip_seq: %h %h %h required 028 14a 13e",
                 strobe_q[0], strobe_q[1], strobe_q[2]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, found;
    int n, blocked;
    logic [8:0] exp_s;
    strobe_q.delete();
    busy = 1'b1;
    clk_en = 1'b0;
    push_pair(8'h40, 8'h00, ok);
    wait_write(20, n, found);
    tick();
    wait_write(20, n, found);
    tick();
    n_tests++;
    if (!found || cpu_a0 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_primer: data strobe found=%b, required 1", found);
    end
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'h30 + 8'(i);
      req_data = 8'h01 + 8'(i);
      n_tests++;
      if (req_ready !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL b2b_ready%0d: got %b required 1", i, req_ready);
      end
      tick();
    end
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_full: req_ready=%b required 0", req_ready);
    end
    req_addr = 8'h34;
    req_data = 8'h05;
    blocked = 0;
    for (int i = 0; i < 5; i++) begin
      if (req_ready)
        blocked++;
      tick();
    end
    n_tests++;
    if (blocked != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_holdoff: ready seen %0d cycles while full, required 0", blocked);
    end
    busy = 1'b0;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    n_tests++;
    if (n != 2) begin
      n_fail++;
      $display("[TB] FAIL b2b_release: ready after %0d cycles, required 2", n);
    end
    wait_idle("b2b");
    tick();
    n_tests++;
    if (strobe_q.size() != 12) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: %0d strobes, required 12", strobe_q.size());
    end else begin
      blocked = 0;
      for (int i = 0; i < 12; i++) begin
        if (i == 0) exp_s = 9'h040;
        else if (i == 1) exp_s = 9'h100;
        else if (i % 2 == 0) exp_s = {1'b0, 8'h30 + 8'((i - 2) / 2)};
        else exp_s = {1'b1, 8'h01 + 8'((i - 3) / 2)};
        if (strobe_q[i] !== exp_s)
          blocked++;
      end
      n_tests++;
      if (blocked != 0) begin
        n_fail++;
        $display("[TB] FAIL b2b_order: %0d strobes out of order, last %h required 105",
                 blocked, strobe_q[11]);
      end
    end
    clk_en = 1'b1;
  endtask

  task automatic test_busy_wait();
    bit ok, found;
    int n, early;
    busy = 1'b1;
    clk_en = 1'b1;
    push_pair(8'h50, 8'h11, ok);
    push_pair(8'h51, 8'h22, ok);
    wait_write(20, n, found);
    tick();
    wait_write(20, n, found);
    n_tests++;
    if (!found || cpu_a0 !== 1'b1 || cpu_din !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL busy_data: a0/din=%b/%h required 1/11", cpu_a0, cpu_din);
    end
    early = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (cpu_write)
        early++;
    end
    n_tests++;
    if (early != 0 || timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_hold: %0d strobes, timeout=%b, required 0 and 0", early, timeout);
    end
    busy = 1'b0;
    wait_write(10, n, found);
    n_tests++;
    if (!found || n != 2 || cpu_a0 !== 1'b0 || cpu_din !== 8'h51) begin
      n_fail++;
      $display("[TB] FAIL busy_release: strobe after %0d cycles a0/din=%b/%h required 2 0/51",
               n, cpu_a0, cpu_din);
    end
    wait_idle("busy");
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_no_timeout: timeout=%b required 0", timeout);
    end
  endtask

  task automatic test_timeout_and_abort();
    bit ok, found;
    int n, early;
    busy = 1'b1;
    halfrate = 1'b1;
    push_pair(8'h60, 8'hAA, ok);
    push_pair(8'h61, 8'hBB, ok);
    wait_write(20, n, found);
    tick();
    wait_write(20, n, found);
    n_tests++;
    if (!found || cpu_din !== 8'hAA) begin
      n_fail++;
      $display("[TB] FAIL tmo_data: din=%h required aa", cpu_din);
    end
    early = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (cpu_write)
        early++;
    end
    n_tests++;
    if (early != 0 || timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tmo_early: %0d strobes timeout=%b, required 0 and 0", early, timeout);
    end
    n = 0;
    while (!timeout && n < 30) begin
      tick();
      n++;
    end
    n_tests++;
    if (timeout !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL tmo_set: timeout=%b required 1", timeout);
    end
    wait_write(10, n, found);
    n_tests++;
    if (!found || cpu_a0 !== 1'b0 || cpu_din !== 8'h61) begin
      n_fail++;
      $display("[TB] FAIL tmo_next: a0/din=%b/%h required 0/61", cpu_a0, cpu_din);
    end
    push_pair(8'h70, 8'h01, ok);
    push_pair(8'h71, 8'h02, ok);
    push_pair(8'h72, 8'h03, ok);
    for (int i = 0; i < 4; i++)
      tick();
    n_tests++;
    if (timeout !== 1'b1 || idle !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL tmo_sticky: timeout/idle=%b/%b required 1/0", timeout, idle);
    end
    halfrate = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_write || !idle || !req_ready)
        early++;
    end
    n_tests++;
    if (early != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: %0d bad cycles (write/idle/ready), required 0", early);
    end
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_timeout_clear: timeout=%b required 0", timeout);
    end
  endtask

  task automatic test_after_reset();
    bit ok, found;
    int n;
    busy = 1'b0;
    clk_en = 1'b1;
    push_pair(8'h00, 8'h5A, ok);
    wait_write(10, n, found);
    n_tests++;
    if (!found || cpu_a0 !== 1'b0 || cpu_din !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL post_rst_addr: found=%b a0/din=%b/%h required 1 0/00", found, cpu_a0, cpu_din);
    end
    wait_idle("post_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_addr_skip();
    test_back_to_back();
    test_busy_wait();
    test_timeout_and_abort();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
